// File: rtl/lcd_hd44780_model.sv
// Display-side responder for an HD44780-style write bus: decodes host strobes into a 2x16
// character image, models command execution time and flags protocol violations.
module lcd_hd44780_model #(
    parameter int unsigned BUSY_CYCLES  = 40,
    parameter int unsigned CLEAR_CYCLES = 160
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rs,
    input  logic         rw,
    input  logic         en,
    input  logic [7:0]   data,
    output logic [127:0] line1,
    output logic [127:0] line2,
    output logic [6:0]   ddram_addr,
    output logic         disp_on,
    output logic         busy,
    output logic         wr_strobe,
    output logic         err
);

    typedef enum logic [1:0] {StIdle, StClear, StBusy} state_e;

    localparam int unsigned CntW      = 16;
    localparam bit          ClearTail = (CLEAR_CYCLES > 32);

    state_e         state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic           en_q, rs_q, rw_q;
    logic [7:0]     d_q;
    logic [6:0]     addr_q, addr_d;
    logic           inc_q, inc_d;
    logic           disp_q, disp_d;
    logic [127:0]   img1_q, img1_d;
    logic [127:0]   img2_q, img2_d;
    logic           strobe_q, strobe_d;
    logic           err_q, err_d;
    logic           fall;

    // Addresses past the end of a row (0x28-0x3F, 0x68-0x7F) step as if they were 0x27/0x67.
    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up);
        logic [6:0] b;
        if (!a[6]) b = (a > 7'h27) ? 7'h27 : a;
        else       b = (a > 7'h67) ? 7'h67 : a;
        if (up) begin
            if (b == 7'h27)      return 7'h40;
            else if (b == 7'h67) return 7'h00;
            else                 return b + 7'd1;
        end else begin
            if (b == 7'h00)      return 7'h67;
            else if (b == 7'h40) return 7'h27;
            else                 return b - 7'd1;
        end
    endfunction

    assign fall = en_q & ~en;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        inc_d    = inc_q;
        disp_d   = disp_q;
        img1_d   = img1_q;
        img2_d   = img2_q;
        strobe_d = 1'b0;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    if (rw_q) begin
                        err_d = 1'b1;
                    end else begin
                        strobe_d = 1'b1;
                        state_d  = StBusy;
                        cnt_d    = CntW'(BUSY_CYCLES - 1);
                        if (rs_q) begin
                            // Only 0x00-0x0F and 0x40-0x4F map onto visible cells.
                            if (addr_q[5:4] == 2'b00) begin
                                if (addr_q[6]) img2_d[{addr_q[3:0], 3'b000} +: 8] = d_q;
                                else           img1_d[{addr_q[3:0], 3'b000} +: 8] = d_q;
                            end
                            addr_d = step_addr(addr_q, inc_q);
                        end else begin
                            unique casez (d_q)
                                8'b1???????: addr_d = d_q[6:0];
                                8'b01??????: ;
                                8'b001?????: ;
                                8'b0001????: ;
                                8'b00001???: disp_d = d_q[2];
                                8'b000001??: inc_d = d_q[1];
                                8'b0000001?: begin
                                    addr_d = 7'h00;
                                    cnt_d  = CntW'(CLEAR_CYCLES - 1);
                                end
                                8'b00000001: begin
                                    addr_d  = 7'h00;
                                    inc_d   = 1'b1;
                                    state_d = StClear;
                                    cnt_d   = '0;
                                end
                                8'b00000000: ;
                                default: ;
                            endcase
                        end
                    end
                end
            end
            StClear: begin
                if (fall) err_d = 1'b1;
                if (cnt_q[4]) img2_d[{cnt_q[3:0], 3'b000} +: 8] = 8'h20;
                else          img1_d[{cnt_q[3:0], 3'b000} +: 8] = 8'h20;
                if (cnt_q[4:0] == 5'd31) begin
                    if (ClearTail) begin
                        state_d = StBusy;
                        cnt_d   = CntW'(CLEAR_CYCLES - 33);
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBusy: begin
                if (fall) err_d = 1'b1;
                if (cnt_q == '0) state_d = StIdle;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            en_q     <= 1'b0;
            rs_q     <= 1'b0;
            rw_q     <= 1'b0;
            d_q      <= 8'h00;
            addr_q   <= 7'h00;
            inc_q    <= 1'b1;
            disp_q   <= 1'b0;
            img1_q   <= {16{8'h20}};
            img2_q   <= {16{8'h20}};
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            en_q     <= en;
            rs_q     <= rs;
            rw_q     <= rw;
            d_q      <= data;
            addr_q   <= addr_d;
            inc_q    <= inc_d;
            disp_q   <= disp_d;
            img1_q   <= img1_d;
            img2_q   <= img2_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
        end
    end

    assign line1      = img1_q;
    assign line2      = img2_q;
    assign ddram_addr = addr_q;
    assign disp_on    = disp_q;
    assign busy       = (state_q != StIdle);
    assign wr_strobe  = strobe_q;
    assign err        = err_q;

endmodule

// File: tb/tb_lcd_hd44780_model.sv
// Directed bench for lcd_hd44780_model: hand-computed image, address and busy-time expectations.
module tb_lcd_hd44780_model;

    localparam int unsigned BusyCycles  = 40;
    localparam int unsigned ClearCycles = 160;
    localparam logic [127:0] Blank = {16{8'h20}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rs = 1'b0;
    logic         rw = 1'b0;
    logic         en = 1'b0;
    logic [7:0]   data = 8'h00;
    logic [127:0] line1, line2;
    logic [6:0]   ddram_addr;
    logic         disp_on, busy, wr_strobe, err;

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt = 0;
    int base_cnt;
    int len;
    logic [127:0] exp1, exp2;

    lcd_hd44780_model #(
        .BUSY_CYCLES (BusyCycles),
        .CLEAR_CYCLES(ClearCycles)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rs        (rs),
        .rw        (rw),
        .en        (en),
        .data      (data),
        .line1     (line1),
        .line2     (line2),
        .ddram_addr(ddram_addr),
        .disp_on   (disp_on),
        .busy      (busy),
        .wr_strobe (wr_strobe),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_strobe) strobe_cnt++;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic strobe(input logic s, input logic w, input logic [7:0] d);
        @(negedge clk);
        rs   = s;
        rw   = w;
        data = d;
        en   = 1'b1;
        @(negedge clk);
        en   = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000 && busy; i++) @(negedge clk);
        if (busy) check_eq("idle_timeout", busy, 1'b0);
    endtask

    // Strobe once idle, then count the negedges on which busy is high.
    task automatic send(input logic s, input logic [7:0] d, output int blen);
        wait_idle();
        strobe(s, 1'b0, d);
        blen = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (busy) blen++;
            else break;
        end
    endtask

    initial begin
        // T1 reset
        do_reset();
        @(negedge clk);
        check_eq("rst_line1", line1, Blank);
        check_eq("rst_line2", line2, Blank);
        check_eq("rst_addr", ddram_addr, 7'h00);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_disp", disp_on, 1'b0);
        check_eq("rst_strobe", wr_strobe, 1'b0);

        // T2 row 0 writes
        exp1 = Blank;
        exp2 = Blank;
        base_cnt = strobe_cnt;
        send(1'b0, 8'h80, len); check_eq("t2_busy_cmd", len, BusyCycles);
        send(1'b1, 8'h49, len); check_eq("t2_busy_d0", len, BusyCycles);
        send(1'b1, 8'h20, len); check_eq("t2_busy_d1", len, BusyCycles);
        send(1'b1, 8'h61, len); check_eq("t2_busy_d2", len, BusyCycles);
        exp1[23:0] = 24'h612049;
        check_eq("t2_line1", line1, exp1);
        check_eq("t2_addr", ddram_addr, 7'h03);
        check_eq("t2_strobes", strobe_cnt - base_cnt, 4);
        check_eq("t2_err", err, 1'b0);

        // T3 row 1, hidden region and wrap
        send(1'b0, 8'hC0, len);
        send(1'b1, 8'h41, len);
        exp2[7:0] = 8'h41;
        check_eq("t3_line2", line2, exp2);
        check_eq("t3_addr41", ddram_addr, 7'h41);
        send(1'b0, 8'h8F, len);
        send(1'b1, 8'h58, len);
        send(1'b1, 8'h59, len);
        exp1[127:120] = 8'h58;
        check_eq("t3_line1", line1, exp1);
        check_eq("t3_line2b", line2, exp2);
        check_eq("t3_addr11", ddram_addr, 7'h11);
        send(1'b0, 8'hA7, len);
        send(1'b1, 8'h5A, len);
        check_eq("t3_wrap_addr", ddram_addr, 7'h40);
        check_eq("t3_wrap_l1", line1, exp1);
        check_eq("t3_wrap_l2", line2, exp2);

        // T4 clear, then reset part way through a second clear
        send(1'b0, 8'h01, len);
        check_eq("t4_busy_clr", len, ClearCycles);
        check_eq("t4_line1", line1, Blank);
        check_eq("t4_line2", line2, Blank);
        check_eq("t4_addr", ddram_addr, 7'h00);
        wait_idle();
        strobe(1'b0, 1'b0, 8'h01);
        repeat (10) @(negedge clk);
        check_eq("t4_busy_mid", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t4_busy_abort", busy, 1'b0);
        rst = 1'b0;

        // T5 strobe while busy
        do_reset();
        base_cnt = strobe_cnt;
        strobe(1'b0, 1'b0, 8'h80);
        strobe(1'b1, 1'b0, 8'h55);
        @(negedge clk);
        check_eq("t5_err_busy", err, 1'b1);
        wait_idle();
        check_eq("t5_line1", line1, Blank);
        check_eq("t5_addr", ddram_addr, 7'h00);
        check_eq("t5_strobes", strobe_cnt - base_cnt, 1);

        // T5 read strobe
        do_reset();
        check_eq("t5_err_clr", err, 1'b0);
        base_cnt = strobe_cnt;
        strobe(1'b1, 1'b1, 8'h41);
        repeat (2) @(negedge clk);
        check_eq("t5_err_rw", err, 1'b1);
        check_eq("t5_rw_strobes", strobe_cnt - base_cnt, 0);
        check_eq("t5_rw_busy", busy, 1'b0);
        check_eq("t5_rw_line1", line1, Blank);
        rw = 1'b0;

        // T6 decrement mode, display on, home
        do_reset();
        send(1'b0, 8'h04, len);
        send(1'b0, 8'h80, len);
        send(1'b1, 8'h42, len);
        exp1 = Blank;
        exp1[7:0] = 8'h42;
        check_eq("t6_line1", line1, exp1);
        check_eq("t6_addr", ddram_addr, 7'h67);
        send(1'b1, 8'h43, len);
        check_eq("t6_hidden_addr", ddram_addr, 7'h66);
        check_eq("t6_hidden_l1", line1, exp1);
        send(1'b0, 8'h0C, len);
        check_eq("t6_disp", disp_on, 1'b1);
        send(1'b0, 8'h02, len);
        check_eq("t6_home_busy", len, ClearCycles);
        check_eq("t6_home_addr", ddram_addr, 7'h00);
        check_eq("t6_home_l1", line1, exp1);
        check_eq("t6_err", err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
